// File: rtl/hist_builder_mc.sv
// hist_builder_mc: multi-channel dToF histogram builder with saturating RMW accumulation and valid/ready bin readout
module hist_builder_mc #(
  parameter int CH_NUM = 2,
  parameter int BIN_W = 6,
  parameter int CNT_W = 8,
  parameter int ACQ_W = 10,
  localparam int CH_W = CH_NUM > 1 ? $clog2(CH_NUM) : 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [ACQ_W-1:0] acq_num,
  input  logic             cyc_end,
  input  logic             hit_vld,
  input  logic [CH_W-1:0]  hit_ch,
  input  logic [BIN_W-1:0] hit_bin,
  output logic             busy,
  output logic             rd_vld,
  input  logic             rd_ready,
  output logic [CH_W-1:0]  rd_ch,
  output logic [BIN_W-1:0] rd_bin,
  output logic [CNT_W-1:0] rd_cnt,
  output logic             rd_last,
  output logic             sat_flag,
  output logic [7:0]       drop_cnt,
  output logic             frame_done
);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH_NUM - 1);
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CH_NUM);
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DUMP} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] mem [CH_NUM][2**BIN_W];
  logic [ACQ_W-1:0] acq_lat, cyc_cnt;
  logic [BIN_W-1:0] clr_addr, f_bin, s1_bin;
  logic [CH_W-1:0] f_ch, s1_ch;
  logic [CNT_W-1:0] s1_dat, wr_val;
  logic f_done, drn, s1_vld, acc_ok, fin_cyc, take, xfer, f_last;
  assign busy = state != IDLE;
  assign acc_ok = state == ACCUM && hit_vld && {1'b0, hit_ch} < CH_LIM;
  assign fin_cyc = state == ACCUM && cyc_end && cyc_cnt == acq_lat - ACQ_W'(1);
  assign xfer = rd_vld && rd_ready;
  assign take = state == DUMP && !f_done && (!rd_vld || rd_ready);
  assign f_last = f_ch == LAST_CH && f_bin == '1;
  assign wr_val = s1_dat == '1 ? s1_dat : s1_dat + CNT_W'(1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? CLEAR : IDLE;
      CLEAR:   state_nx = clr_addr == '1 ? ACCUM : CLEAR;
      ACCUM:   state_nx = fin_cyc ? DRAIN : ACCUM;
      DRAIN:   state_nx = drn ? DUMP : DRAIN;
      DUMP:    state_nx = xfer && rd_last ? IDLE : DUMP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!res) begin
      state <= IDLE;
      acq_lat <= '0;
      cyc_cnt <= '0;
      clr_addr <= '0;
      drn <= 1'b0;
      f_ch <= '0;
      f_bin <= '0;
      f_done <= 1'b0;
      s1_vld <= 1'b0;
      rd_vld <= 1'b0;
      rd_ch <= '0;
      rd_bin <= '0;
      rd_cnt <= '0;
      rd_last <= 1'b0;
      sat_flag <= 1'b0;
      drop_cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nx;
      s1_vld <= acc_ok;
      frame_done <= state == DUMP && xfer && rd_last;
      drn <= state == DRAIN && !drn;
      clr_addr <= state == CLEAR ? clr_addr + BIN_W'(1) : '0;
      if (state == IDLE && start) begin
        acq_lat <= acq_num == '0 ? ACQ_W'(1) : acq_num;
        cyc_cnt <= '0;
        sat_flag <= 1'b0;
        drop_cnt <= '0;
        f_ch <= '0;
        f_bin <= '0;
        f_done <= 1'b0;
      end else begin
        if (state == ACCUM && cyc_end) cyc_cnt <= cyc_cnt + ACQ_W'(1);
        if (s1_vld && s1_dat == '1) sat_flag <= 1'b1;
        if (hit_vld && !acc_ok && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      end
      if (xfer) rd_vld <= 1'b0;
      if (take) begin
        rd_vld <= 1'b1;
        rd_ch <= f_ch;
        rd_bin <= f_bin;
        rd_cnt <= mem[f_ch][f_bin];
        rd_last <= f_last;
        f_done <= f_last;
        f_bin <= f_bin + BIN_W'(1);
        if (f_bin == '1) f_ch <= f_ch + CH_W'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    s1_ch <= hit_ch;
    s1_bin <= hit_bin;
    s1_dat <= s1_vld && s1_ch == hit_ch && s1_bin == hit_bin ? wr_val : mem[hit_ch][hit_bin];
    if (state == CLEAR) begin
      for (int c = 0; c < CH_NUM; c++) mem[c][clr_addr] <= '0;
    end else if (s1_vld) begin
      mem[s1_ch][s1_bin] <= wr_val;
    end
  end
endmodule
